icache_dm: RTL and testbench

Read-only, direct-mapped L1 instruction cache between the pipeline's instruction-fetch port and the 128-bit line-wide instruction memory. It serves 32-bit word fetches in zero extra cycles on a hit. On a miss it stalls the core, refills one 4-word line from memory and then completes the fetch. The pipeline byte-swaps fetched words itself, so this block returns memory words unmodified.

---
 rtl/icache_dm.sv | 76 +++++++
 tb/tb_icache_dm.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// icache_dm: read-only direct-mapped L1 instruction cache with single-line refill
//   clk, proc_reset (sync, active-high)
//   proc_read/proc_write/proc_addr/proc_wdata -> proc_rdata/proc_stall : fetch port (writes ignored)
//   mem_read/mem_write/mem_addr/mem_wdata <- mem_rdata/mem_ready       : 128-bit line memory port
module icache_dm #(
  parameter int NLINE = 8,
  localparam int IW = $clog2(NLINE),
  localparam int TAGW = 28 - IW
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FETCH = 1'b1;
  logic [0:0] state;
  logic [27:0] miss_addr;
  logic [NLINE-1:0] valid;
  logic [TAGW-1:0] tags [NLINE];
  logic [127:0] data [NLINE];
  logic [IW-1:0] idx;
  logic [IW-1:0] fidx;
  logic [TAGW-1:0] tag;
  logic [127:0] line;
  logic hit;
  logic fetch;
  logic fill;
  logic unused;
  assign unused = ^{proc_write, proc_wdata};
  assign idx = proc_addr[IW+1:2];
  assign tag = proc_addr[29:IW+2];
  assign fidx = miss_addr[IW-1:0];
  assign fetch = state == FETCH;
  assign fill = fetch & mem_ready & ~proc_reset;
  assign hit = proc_read & valid[idx] & (tags[idx] == tag);
  assign line = data[idx];
  assign proc_rdata = line[{proc_addr[1:0], 5'd0} +: 32];
  // valid bits may still be stale on the first reset cycle, so reset forces a miss
  assign proc_stall = proc_reset ? proc_read : fetch | (proc_read & ~hit);
  assign mem_read = fetch;
  assign mem_addr = fetch ? miss_addr : '0;
  assign mem_write = 1'b0;
  assign mem_wdata = '0;
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state <= IDLE;
      valid <= '0;
      miss_addr <= '0;
    end else if (fetch) begin
      if (mem_ready) begin
        valid[fidx] <= 1'b1;
        state <= IDLE;
      end
    end else if (proc_read & ~hit) begin
      miss_addr <= proc_addr[29:2];
      state <= FETCH;
    end
  end
  always_ff @(posedge clk) begin
    if (fill) begin
      data[fidx] <= mem_rdata;
      tags[fidx] <= miss_addr[27:IW];
    end
  end
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: table-driven cycle checks of icache_dm plus a slow-memory sequence
module tb_icache_dm;
  logic clk = 0;
  logic proc_reset, proc_read, proc_write, mem_ready;
  logic [29:0] proc_addr;
  logic [31:0] proc_wdata, proc_rdata;
  logic proc_stall, mem_read, mem_write;
  logic [27:0] mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  int checks = 0;
  int errors = 0;
  int refills = 0;
  logic mr_d = 0;

  typedef struct {
    logic rst, rd, wr;
    logic [29:0] a;
    logic rdy;
    logic st, mr;
    logic [27:0] ma;
    logic crd;
    logic [31:0] rdv;
  } row_t;
  row_t rows[$];

  icache_dm dut (
    .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_rdata(proc_rdata),
    .proc_stall(proc_stall), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // memory image: word w of line la = 0x11111111*(w+1) ^ ((la-1) << 16); line 1 is 1111..4444
  function automatic logic [31:0] wd(input logic [27:0] la, input int w);
    logic [15:0] h;
    h = la[15:0] - 16'd1;
    return (32'h1111_1111 * (w + 1)) ^ {h, 16'h0};
  endfunction
  function automatic logic [31:0] ew(input logic [29:0] a);
    return wd(a[29:2], int'(a[1:0]));
  endfunction
  assign mem_rdata = {wd(mem_addr, 3), wd(mem_addr, 2), wd(mem_addr, 1), wd(mem_addr, 0)};

  always @(posedge clk) begin
    mr_d <= mem_read;
    if (mem_read & ~mr_d) refills <= refills + 1;
  end

  function automatic row_t r(input logic rst, rd, wr, input logic [29:0] a, input logic rdy,
                             input logic st, mr, input logic [27:0] ma, input logic crd,
                             input logic [31:0] rdv);
    row_t x;
    x.rst = rst; x.rd = rd; x.wr = wr; x.a = a; x.rdy = rdy;
    x.st = st; x.mr = mr; x.ma = ma; x.crd = crd; x.rdv = rdv;
    return x;
  endfunction

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, got, exp);
    end
  endtask

  task automatic drive(input logic rst, rd, input logic [29:0] a, input logic rdy);
    proc_reset = rst; proc_read = rd; proc_addr = a; mem_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic miss1(input logic [29:0] a);
    rows.push_back(r(0, 1, 0, a, 0, 1, 0, 28'h0, 0, 0));
    rows.push_back(r(0, 1, 0, a, 1, 1, 1, a[29:2], 0, 0));
    rows.push_back(r(0, 1, 0, a, 0, 0, 0, 28'h0, 1, ew(a)));
  endtask

  initial begin
    proc_write = 0; proc_wdata = 0;
    drive(1, 0, 0, 0);
    repeat (2) tick();
    rows.push_back(r(1, 1, 0, 30'h5, 0, 1, 0, 28'h0, 0, 0));
    rows.push_back(r(1, 0, 0, 30'h5, 1, 0, 0, 28'h0, 0, 0));
    for (int i = 0; i < 3; i++)
      rows.push_back(r(0, 1, 0, 30'h5, 0, 1, i != 0, i != 0 ? 28'h1 : 28'h0, 0, 0));
    rows.push_back(r(0, 1, 0, 30'h5, 1, 1, 1, 28'h1, 0, 0));
    rows.push_back(r(0, 1, 0, 30'h5, 0, 0, 0, 28'h0, 1, 32'h2222_2222));
    rows.push_back(r(0, 1, 0, 30'h4, 0, 0, 0, 28'h0, 1, 32'h1111_1111));
    rows.push_back(r(0, 1, 0, 30'h5, 0, 0, 0, 28'h0, 1, 32'h2222_2222));
    rows.push_back(r(0, 1, 0, 30'h6, 0, 0, 0, 28'h0, 1, 32'h3333_3333));
    rows.push_back(r(0, 1, 0, 30'h7, 0, 0, 0, 28'h0, 1, 32'h4444_4444));
    rows.push_back(r(0, 0, 0, 30'h3FFF_FFFF, 1, 0, 0, 28'h0, 0, 0));
    rows.push_back(r(0, 0, 1, 30'h123, 1, 0, 0, 28'h0, 0, 0));
    rows.push_back(r(0, 0, 0, 30'h100, 0, 0, 0, 28'h0, 0, 0));
    rows.push_back(r(0, 1, 1, 30'h5, 0, 0, 0, 28'h0, 1, 32'h2222_2222));
    miss1(30'h100);
    miss1(30'h20);
    miss1(30'h24);
    rows.push_back(r(0, 1, 0, 30'h5, 0, 1, 0, 28'h0, 0, 0));
    rows.push_back(r(0, 1, 0, 30'h5, 1, 1, 1, 28'h1, 0, 0));
    rows.push_back(r(0, 1, 0, 30'h5, 0, 0, 0, 28'h0, 1, 32'h2222_2222));
    rows.push_back(r(0, 1, 0, 30'h48, 0, 1, 0, 28'h0, 0, 0));
    rows.push_back(r(0, 1, 0, 30'h48, 0, 1, 1, 28'h12, 0, 0));
    rows.push_back(r(1, 1, 0, 30'h48, 0, 1, 1, 28'h12, 0, 0));
    rows.push_back(r(0, 0, 0, 30'h48, 1, 0, 0, 28'h0, 0, 0));
    rows.push_back(r(0, 1, 0, 30'h48, 0, 1, 0, 28'h0, 0, 0));
    rows.push_back(r(0, 1, 0, 30'h48, 1, 1, 1, 28'h12, 0, 0));
    rows.push_back(r(0, 1, 0, 30'h48, 0, 0, 0, 28'h0, 1, ew(30'h48)));
    rows.push_back(r(0, 1, 0, 30'h4, 0, 1, 0, 28'h0, 0, 0));
    rows.push_back(r(1, 0, 0, 30'h4, 0, 0, 1, 28'h1, 0, 0));
    foreach (rows[i]) begin
      proc_write = rows[i].wr;
      drive(rows[i].rst, rows[i].rd, rows[i].a, rows[i].rdy);
      #2;
      chk($sformatf("row%0d stall", i), 32'(proc_stall), 32'(rows[i].st));
      if (!(rows[i].rst && rows[i].rd && rows[i].mr)) begin
        chk($sformatf("row%0d mem_read", i), 32'(mem_read), 32'(rows[i].mr));
        chk($sformatf("row%0d mem_addr", i), 32'(mem_addr), 32'(rows[i].ma));
      end
      if (rows[i].crd) chk($sformatf("row%0d rdata", i), proc_rdata, rows[i].rdv);
      chk($sformatf("row%0d mem_write", i), 32'(mem_write), 0);
      chk($sformatf("row%0d mem_wdata", i), 32'(mem_wdata[31:0] | mem_wdata[127:96]), 0);
      tick();
    end
    proc_write = 0;
    drive(0, 0, 0, 0);
    tick();
    refills = 0;
    drive(0, 1, 30'h80, 0);
    #2 chk("slow first stall", 32'(proc_stall), 1);
    for (int c = 1; c <= 10; c++) begin
      tick();
      drive(0, 1, (c % 2) ? 30'h1234 : 30'h3FFF_FFF0 + 30'(c), c == 10);
      #2;
      chk($sformatf("slow c%0d stall", c), 32'(proc_stall), 1);
      chk($sformatf("slow c%0d mem_read", c), 32'(mem_read), 1);
      chk($sformatf("slow c%0d mem_addr", c), 32'(mem_addr), 32'h20);
    end
    tick();
    drive(0, 1, 30'h80, 0);
    #2;
    chk("slow hit stall", 32'(proc_stall), 0);
    chk("slow hit rdata", proc_rdata, ew(30'h80));
    chk("slow mem_read drop", 32'(mem_read), 0);
    tick();
    drive(0, 1, 30'h83, 0);
    #2 chk("slow hit word3", proc_rdata, ew(30'h83));
    chk("slow refill count", 32'(refills), 1);
    tick();
    drive(0, 1, 30'h1234, 0);
    #2 chk("toggled addr misses", 32'(proc_stall), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
